// File: rtl/pic_bus_control_seq.sv
// 8259-style data-bus control: strobe sampling, write-data latch, ICW/OCW decode and init sequencing.
// Optional build macro PIC_STROBE_SYNC_EN adds two-flop synchronizers on CS#/RD#/WR#/A0.
module pic_bus_control_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  write_icw1,
  output logic                  write_icw2,
  output logic                  write_icw3,
  output logic                  write_icw4,
  output logic                  write_ocw1,
  output logic                  write_ocw2,
  output logic                  write_ocw3,
  output logic                  read,
  output logic                  read_select_isr,
  output logic                  init_done,
  output logic                  seq_error
);

  typedef enum logic [1:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} state_t;

  state_t state, state_next;
  logic   single_mode, single_mode_next;
  logic   icw4_needed, icw4_needed_next;
  logic   init_done_next, seq_error_next, read_select_isr_next;
  logic   icw1_next, icw2_next, icw3_next, icw4_next;
  logic   ocw1_next, ocw2_next, ocw3_next;

  logic cs_n, rd_n, wr_n, a0;

`ifdef PIC_STROBE_SYNC_EN
  logic [1:0] cs_sync, rd_sync, wr_sync, a_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync <= 2'b11;
      rd_sync <= 2'b11;
      wr_sync <= 2'b11;
      a_sync  <= 2'b00;
    end else begin
      cs_sync <= {cs_sync[0], chip_select_n};
      rd_sync <= {rd_sync[0], read_enable_n};
      wr_sync <= {wr_sync[0], write_enable_n};
      a_sync  <= {a_sync[0], address};
    end
  end

  assign cs_n = cs_sync[1];
  assign rd_n = rd_sync[1];
  assign wr_n = wr_sync[1];
  assign a0   = a_sync[1];
`else
  assign cs_n = chip_select_n;
  assign rd_n = read_enable_n;
  assign wr_n = write_enable_n;
  assign a0   = address;
`endif

  logic wr_act, wr_prev, addr_latched, commit;

  assign wr_act = !cs_n && !wr_n;
  // Either CS# or WR# going high ends the write window.
  assign commit = wr_prev && !wr_act;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_prev           <= 1'b0;
      addr_latched      <= 1'b0;
      internal_data_bus <= '0;
      read              <= 1'b0;
    end else begin
      wr_prev <= wr_act;
      read    <= !cs_n && !rd_n && !wr_act;
      if (wr_act) begin
        internal_data_bus <= data_bus_in;
        addr_latched      <= a0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      single_mode     <= 1'b0;
      icw4_needed     <= 1'b0;
      init_done       <= 1'b0;
      seq_error       <= 1'b0;
      read_select_isr <= 1'b0;
      write_icw1      <= 1'b0;
      write_icw2      <= 1'b0;
      write_icw3      <= 1'b0;
      write_icw4      <= 1'b0;
      write_ocw1      <= 1'b0;
      write_ocw2      <= 1'b0;
      write_ocw3      <= 1'b0;
    end else begin
      state           <= state_next;
      single_mode     <= single_mode_next;
      icw4_needed     <= icw4_needed_next;
      init_done       <= init_done_next;
      seq_error       <= seq_error_next;
      read_select_isr <= read_select_isr_next;
      write_icw1      <= icw1_next;
      write_icw2      <= icw2_next;
      write_icw3      <= icw3_next;
      write_icw4      <= icw4_next;
      write_ocw1      <= ocw1_next;
      write_ocw2      <= ocw2_next;
      write_ocw3      <= ocw3_next;
    end
  end

  always_comb begin
    state_next           = state;
    single_mode_next     = single_mode;
    icw4_needed_next     = icw4_needed;
    init_done_next       = init_done;
    seq_error_next       = seq_error;
    read_select_isr_next = read_select_isr;
    icw1_next            = 1'b0;
    icw2_next            = 1'b0;
    icw3_next            = 1'b0;
    icw4_next            = 1'b0;
    ocw1_next            = 1'b0;
    ocw2_next            = 1'b0;
    ocw3_next            = 1'b0;

    if (commit) begin
      if (!addr_latched) begin
        if (internal_data_bus[4]) begin
          icw1_next        = 1'b1;
          single_mode_next = internal_data_bus[1];
          icw4_needed_next = internal_data_bus[0];
          init_done_next   = 1'b0;
          seq_error_next   = 1'b0;
          state_next       = WAIT_ICW2;
        end else if (state != IDLE) begin
          // Operation commands are refused mid-initialisation.
          seq_error_next = 1'b1;
        end else if (internal_data_bus[3]) begin
          ocw3_next = 1'b1;
          if (internal_data_bus[1]) read_select_isr_next = internal_data_bus[0];
        end else begin
          ocw2_next = 1'b1;
        end
      end else begin
        unique case (state)
          WAIT_ICW2: begin
            icw2_next = 1'b1;
            if (!single_mode) begin
              state_next = WAIT_ICW3;
            end else if (icw4_needed) begin
              state_next = WAIT_ICW4;
            end else begin
              state_next     = IDLE;
              init_done_next = 1'b1;
            end
          end
          WAIT_ICW3: begin
            icw3_next = 1'b1;
            if (icw4_needed) begin
              state_next = WAIT_ICW4;
            end else begin
              state_next     = IDLE;
              init_done_next = 1'b1;
            end
          end
          WAIT_ICW4: begin
            icw4_next      = 1'b1;
            state_next     = IDLE;
            init_done_next = 1'b1;
          end
          default: ocw1_next = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_bus_control_seq.sv
// Directed self-checking bench for pic_bus_control_seq (default 8-bit build).
module tb_pic_bus_control_seq;

`ifdef PIC_STROBE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // Pulse vector bit order: {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_ICW1 = 7'b1000000;
  localparam logic [6:0] P_ICW2 = 7'b0100000;
  localparam logic [6:0] P_ICW3 = 7'b0010000;
  localparam logic [6:0] P_ICW4 = 7'b0001000;
  localparam logic [6:0] P_OCW1 = 7'b0000100;
  localparam logic [6:0] P_OCW3 = 7'b0000001;

  logic       clock = 1'b0;
  logic       reset;
  logic       chip_select_n, read_enable_n, write_enable_n, address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       write_icw1, write_icw2, write_icw3, write_icw4;
  logic       write_ocw1, write_ocw2, write_ocw3;
  logic       read, read_select_isr, init_done, seq_error;

  int tests = 0;
  int fails = 0;
  int n_ocw1 = 0;
  int base;

  pic_bus_control_seq #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
    .write_enable_n(write_enable_n), .address(address),
    .data_bus_in(data_bus_in), .internal_data_bus(internal_data_bus),
    .write_icw1(write_icw1), .write_icw2(write_icw2), .write_icw3(write_icw3),
    .write_icw4(write_icw4), .write_ocw1(write_ocw1), .write_ocw2(write_ocw2),
    .write_ocw3(write_ocw3), .read(read), .read_select_isr(read_select_isr),
    .init_done(init_done), .seq_error(seq_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (write_ocw1) n_ocw1++;

  function automatic logic [6:0] pulses();
    return {write_icw1, write_icw2, write_icw3, write_icw4, write_ocw1, write_ocw2, write_ocw3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One write strobe of one clock; release by WR# or (cs_release) by CS#.
  task automatic do_write(input logic a, input logic [7:0] d, input logic cs_release,
                          input logic [6:0] exp_p, input string tag);
    @(negedge clock);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = a;
    data_bus_in    = d;
    @(negedge clock);
    if (cs_release) chip_select_n = 1'b1;
    else            write_enable_n = 1'b1;
    repeat (LAT) @(posedge clock);
    #1 chk({tag, "_pulse"}, 32'(pulses()), 32'(exp_p));
    @(posedge clock);
    #1 chk({tag, "_one_cycle"}, 32'(pulses()), 32'(P_NONE));
    @(negedge clock);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pulses"}, 32'(pulses()), 32'(P_NONE));
    chk({tag, "_bus"}, 32'(internal_data_bus), 32'h0);
    chk({tag, "_flags"}, 32'({read, read_select_isr, init_done, seq_error}), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    chip_select_n = 1'b1; read_enable_n = 1'b1; write_enable_n = 1'b1;
    address = 1'b0; data_bus_in = 8'h00;
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    @(negedge clock) reset = 1'b0;

    // Single mode with ICW4: ICW1, ICW2, ICW4
    do_write(1'b0, 8'h13, 1'b0, P_ICW1, "icw1_13");
    chk("init_after_icw1", 32'(init_done), 32'h0);
    do_write(1'b1, 8'h20, 1'b0, P_ICW2, "icw2_20");
    chk("init_before_icw4", 32'(init_done), 32'h0);
    do_write(1'b1, 8'h01, 1'b0, P_ICW4, "icw4_01");
    chk("init_after_icw4", 32'(init_done), 32'h1);
    chk("bus_01", 32'(internal_data_bus), 32'h01);

    // Cascade mode, no ICW4: ICW1, ICW2, ICW3
    do_write(1'b0, 8'h10, 1'b0, P_ICW1, "icw1_10");
    do_write(1'b1, 8'h08, 1'b0, P_ICW2, "icw2_08");
    do_write(1'b1, 8'h04, 1'b0, P_ICW3, "icw3_04");
    chk("init_after_icw3", 32'(init_done), 32'h1);

    // Operation commands after init
    do_write(1'b1, 8'hFF, 1'b0, P_OCW1, "ocw1_ff");
    chk("bus_ff", 32'(internal_data_bus), 32'hFF);
    do_write(1'b0, 8'h0B, 1'b0, P_OCW3, "ocw3_0b");
    chk("rsel_isr", 32'(read_select_isr), 32'h1);
    do_write(1'b0, 8'h0A, 1'b0, P_OCW3, "ocw3_0a");
    chk("rsel_irr", 32'(read_select_isr), 32'h0);

    // OCW2 during WAIT_ICW2 is refused
    do_write(1'b0, 8'h13, 1'b0, P_ICW1, "icw1_seq");
    do_write(1'b0, 8'h20, 1'b0, P_NONE, "ocw2_in_init");
    chk("seq_error_set", 32'(seq_error), 32'h1);
    do_write(1'b1, 8'h55, 1'b0, P_ICW2, "icw2_after_err");
    do_write(1'b1, 8'h02, 1'b0, P_ICW4, "icw4_after_err");
    chk("seq_error_sticky", 32'({seq_error, init_done}), 32'h3);
    do_write(1'b0, 8'h1B, 1'b0, P_ICW1, "icw1_clear");
    chk("seq_error_cleared", 32'(seq_error), 32'h0);

    // Reset while waiting for ICW3
    do_write(1'b0, 8'h10, 1'b0, P_ICW1, "icw1_rst");
    do_write(1'b1, 8'h08, 1'b0, P_ICW2, "icw2_rst");
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 check_all_zero("mid_reset");
    @(negedge clock) reset = 1'b0;
    do_write(1'b1, 8'h77, 1'b0, P_OCW1, "ocw1_post_reset");

    // CS# release commits the write
    do_write(1'b1, 8'h3C, 1'b1, P_OCW1, "cs_release");
    chk("bus_3c", 32'(internal_data_bus), 32'h3C);

    // Read suppressed during write, then asserted after WR# release
    @(negedge clock);
    chip_select_n = 1'b0; read_enable_n = 1'b0; write_enable_n = 1'b0;
    address = 1'b1; data_bus_in = 8'h5A;
    repeat (LAT + 1) @(posedge clock);
    #1 chk("read_during_write", 32'(read), 32'h0);
    @(negedge clock) write_enable_n = 1'b1;
    repeat (LAT) @(posedge clock);
    #1 chk("read_after_release", 32'({read, write_ocw1}), 32'h3);
    @(negedge clock);
    chip_select_n = 1'b1; read_enable_n = 1'b1;
    repeat (LAT + 1) @(posedge clock);
    #1 chk("read_deasserted", 32'(read), 32'h0);

    // Back-to-back writes with one idle clock between them
    @(negedge clock);
    base = n_ocw1;
    chip_select_n = 1'b0; write_enable_n = 1'b0; address = 1'b1; data_bus_in = 8'h11;
    @(negedge clock) write_enable_n = 1'b1;
    @(negedge clock) begin write_enable_n = 1'b0; data_bus_in = 8'h22; end
    @(negedge clock) write_enable_n = 1'b1;
    repeat (LAT + 3) @(negedge clock);
    chip_select_n = 1'b1;
    chk("back_to_back_count", 32'(n_ocw1 - base), 32'd2);
    chk("back_to_back_bus", 32'(internal_data_bus), 32'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pic_bus_control_seq.md
Name: pic_bus_control_seq

Overview:
- Clocked, parametrised successor to the 8259 data-bus control decode.
- Samples the asynchronous CS#/RD#/WR#/A0 strobes and latches write data.
- Tracks the ICW1→ICW2→(ICW3)→(ICW4) initialisation sequence in a state machine and emits one-cycle write-type pulses to the internal bus.
- Also tracks the OCW3 read-register select and sits between the CPU bus pins and the IMR, priority-resolver and cascade blocks.

Parameters:
DATA_WIDTH, 8, width of data bus; must be >=8; command fields use bits [4:0]; bits above 7 are latched and passed through unchanged.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
chip_select_n  input  1  CS#, active low
read_enable_n  input  1  RD#, active low
write_enable_n  input  1  WR#, active low
address  input  1  A0
data_bus_in  input  DATA_WIDTH  CPU write data
internal_data_bus  output  DATA_WIDTH  latched write data
write_icw1  output  1  one-cycle ICW1 pulse
write_icw2  output  1  one-cycle ICW2 pulse
write_icw3  output  1  one-cycle ICW3 pulse
write_icw4  output  1  one-cycle ICW4 pulse
write_ocw1  output  1  one-cycle OCW1 pulse
write_ocw2  output  1  one-cycle OCW2 pulse
write_ocw3  output  1  one-cycle OCW3 pulse
read  output  1  registered read-active
read_select_isr  output  1  0=IRR, 1=ISR readback
init_done  output  1  initialisation sequence complete
seq_error  output  1  sticky: OCW2/OCW3 written during init

Behaviour:
- Reset is synchronous and active-high; clock is the only clock. On reset:
  - all outputs 0; internal_data_bus = 0;
  - state = IDLE; single_mode = 0; icw4_needed = 0.
- Write active (wr_act) = !chip_select_n & !write_enable_n, sampled each clock. While wr_act = 1, internal_data_bus <= data_bus_in and the address is captured.
- Write commit occurs on the first clock where wr_act = 0 and prev wr_act = 1. Exactly one write_* pulse is emitted, high for one cycle, in the cycle after the falling edge of wr_act. Latency: one clock from strobe release to pulse.
- Decode at commit (d = latched data, a = latched A0):
  - a=0, d[4]=1: ICW1. Latch single_mode = d[1] and icw4_needed = d[0]; init_done <= 0; state <= WAIT_ICW2. Accepted from any state; restarts the sequence.
  - a=0, d[4]=0, d[3]=0: OCW2. a=0, d[4]=0, d[3]=1: OCW3.
    - If state != IDLE: no pulse, seq_error <= 1.
    - For an accepted OCW3 with d[1]=1 (RR): read_select_isr <= d[0].
  - a=1, state WAIT_ICW2: ICW2. Next state: WAIT_ICW3 if !single_mode; else WAIT_ICW4 if icw4_needed; else IDLE with init_done <= 1.
  - a=1, state WAIT_ICW3: ICW3. Next state: WAIT_ICW4 if icw4_needed, else IDLE with init_done <= 1.
  - a=1, state WAIT_ICW4: ICW4; state <= IDLE; init_done <= 1.
  - a=1, state IDLE: OCW1.
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4. State changes only at a commit or on reset.
- read <= !chip_select_n & !read_enable_n & !wr_act. A read simultaneous with a write is suppressed (read = 0).
- CS# deasserting while WR# is still low counts as write release and commits.
- seq_error is cleared only by reset or by ICW1.
- Reset mid-sequence: returns to IDLE and init_done = 0; any pending commit is discarded.
- Back-to-back writes with a single idle clock between them each produce their own pulse.

Optional Feature:
- Macro: PIC_STROBE_SYNC_EN.
- When defined: chip_select_n, read_enable_n, write_enable_n and address each pass through a two-flop synchronizer (reset to inactive/0) before use. Write commit and read latency each grow by 2 clocks. Data is latched from the synchronized wr_act window.
- When undefined: strobes are sampled directly (single register) as described above.

Test Plan:
- Reset, then ICW1=0x13 (SNGL=1, IC4=1), ICW2=0x20, ICW4=0x01 -> pulses write_icw1, write_icw2, write_icw4 in order; no write_icw3; init_done=1 after ICW4 commit; internal_data_bus=0x01.
- ICW1=0x10, ICW2=0x08, ICW3=0x04 -> write_icw3 asserted; init_done=1 after ICW3 commit; no ICW4 expected.
- After init: A0=1 write 0xFF -> write_ocw1 single-cycle pulse, internal_data_bus=0xFF. Then A0=0 write 0x0B -> write_ocw3, read_select_isr=1. Then write 0x0A -> read_select_isr=0.
- During WAIT_ICW2: A0=0 write 0x20 -> no pulse, seq_error=1, state unchanged. Next A0=1 write -> write_icw2. ICW1 clears seq_error.
- CS#=0, RD#=0 with WR#=0 -> read=0. Release WR# -> read=1 next clock.
- Assert reset in WAIT_ICW3 -> all outputs 0, state IDLE. Next A0=1 write decodes as OCW1.
